// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (RUN / HALT / FAULT)
//   NOP, EBREAK   : instruction encodings the fetch stage recognises
//   DEF_RESET_PC  : default first fetch address after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] EBREAK       = 32'h0010_0073;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clock, nreset   : clock, async active-low reset (clears to NOP/invalid)
//   load            : capture d_instr/d_pc, mark valid
//   flush           : invalidate and force NOP, keep pc (wins over load)
//   clear           : drop valid only (pending instr consumed, nothing new)
//   d_instr, d_pc   : incoming instruction and its byte PC
//   valid, instr, pc: registered outputs to decode
module if_id_reg #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            load,
  input  logic            flush,
  input  logic            clear,
  input  logic [ILEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  import fetch_pkg::*;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      valid <= 1'b0;
      instr <= ILEN'(NOP);
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= ILEN'(NOP);
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, next-PC selection and RUN/HALT/FAULT
// control, feeding an IF/ID register with a valid/ready handshake to decode.
// Ports:
//   clock, nreset          : clock, async active-low reset
//   imem_addr  (out)       : word address into combinational imem (pc[ALEN+1:2])
//   imem_instr (in)        : instruction at imem_addr, same cycle
//   redirect, redirect_pc  : taken branch/jump from execute and its byte target
//   id_ready   (in)        : decode accepts IF/ID contents this cycle
//   id_valid/id_instr/id_pc: IF/ID register contents
//   halted                 : fetch stopped on ebreak
//   fetch_fault            : sticky misaligned-redirect fault
module ifetch
  import fetch_pkg::*;
#(
  parameter int              ALEN     = 6,
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clock,
  input  logic            nreset,
  output logic [ALEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            halted,
  output logic            fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            load;
  logic            flush;
  logic            clear;

  // Address comes straight from the PC register: no path from redirect or
  // id_ready. Upper PC bits simply alias onto the 64-word memory.
  assign imem_addr = pc[ALEN+1:2];

  // redirect outranks load; in FAULT it is ignored entirely.
  assign load  = (state == RUN) && (!id_valid || id_ready) && !redirect;
  assign flush = redirect && (state != FAULT);
  // Outside RUN nothing refills the register, so a consumed entry just drops.
  assign clear = (state != RUN) && id_ready;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        RUN, HALT: begin
          if (redirect) begin
            halted <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
              pc    <= redirect_pc;
              state <= RUN;
            end else begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end
          end else if (load) begin
            pc <= pc + XLEN'(4);
            // ebreak is issued to decode, then fetch stops.
            if (imem_instr == ILEN'(EBREAK)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          // FAULT: sticky until reset.
          state       <= FAULT;
          fetch_fault <= 1'b1;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_if_id (
    .clock   (clock),
    .nreset  (nreset),
    .load    (load),
    .flush   (flush),
    .clear   (clear),
    .d_instr (imem_instr),
    .d_pc    (pc),
    .valid   (id_valid),
    .instr   (id_instr),
    .pc      (id_pc)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: stimulus pushes expected {pc, instr} into a
// scoreboard queue; a negedge monitor pops on every completed handshake.
module tb_ifetch;

  logic        clock = 1'b0;
  logic        nreset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] mem [64];
  logic [63:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign imem_instr = mem[imem_addr];

  ifetch dut (
    .clock       (clock),
    .nreset      (nreset),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .halted      (halted),
    .fetch_fault (fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // Monitor: a handshake completes when valid && ready at the next edge;
  // a same-cycle redirect voids it.
  always @(negedge clock) begin
    if (nreset === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && redirect === 1'b0) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e[63:32]);
        chk("sb_instr", id_instr, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 20);
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193;
    mem[3] = 32'h0040_0213;
    nreset = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_addr", {26'b0, imem_addr}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Sequential run
    nreset = 1'b1; id_ready = 1'b1;
    push(32'h0, 32'h0010_0093);
    push(32'h4, 32'h0020_0113);
    push(32'h8, 32'h0030_0193);
    cyc(1);
    chk("seq_valid", {31'b0, id_valid}, 32'd1);
    chk("seq_pc0", id_pc, 32'h0);
    cyc(2);
    chk("seq_pc8", id_pc, 32'h8);

    // Stall 3 cycles at id_pc=8
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_pc", id_pc, 32'h8);
      chk("stall_instr", id_instr, 32'h0030_0193);
      chk("stall_addr", {26'b0, imem_addr}, 32'd3);
    end
    id_ready = 1'b1;
    cyc(1);
    chk("release_pc", id_pc, 32'hC);
    chk("release_instr", id_instr, 32'h0040_0213);

    // Redirect to 0x20 with ready high: old contents flushed
    redirect = 1'b1; redirect_pc = 32'h20;
    cyc(1);
    redirect = 1'b0;
    chk("redir_valid", {31'b0, id_valid}, 32'd0);
    chk("redir_nop", id_instr, 32'h0000_0013);
    chk("redir_pc_hold", id_pc, 32'hC);
    push(32'h20, 32'h0080_0013);
    cyc(1);
    chk("redir_tgt_pc", id_pc, 32'h20);
    chk("redir_tgt_instr", id_instr, 32'h0080_0013);
    cyc(1);

    // Ebreak at word 2
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    mem[2] = 32'h0010_0073;
    cyc(1);
    redirect = 1'b0; id_ready = 1'b1;
    push(32'h0, 32'h0010_0093);
    push(32'h4, 32'h0020_0113);
    push(32'h8, 32'h0010_0073);
    cyc(3);
    chk("ebrk_pc", id_pc, 32'h8);
    chk("ebrk_valid", {31'b0, id_valid}, 32'd1);
    chk("ebrk_halted", {31'b0, halted}, 32'd1);
    cyc(1);
    chk("halt_valid", {31'b0, id_valid}, 32'd0);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    cyc(2);
    chk("halt_noload", {31'b0, id_valid}, 32'd0);
    chk("halt_addr", {26'b0, imem_addr}, 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0;
    cyc(1);
    redirect = 1'b0;
    chk("unhalt", {31'b0, halted}, 32'd0);
    chk("unhalt_valid", {31'b0, id_valid}, 32'd0);
    push(32'h0, 32'h0010_0093);
    cyc(1);
    chk("unhalt_pc", id_pc, 32'h0);
    cyc(1);
    id_ready = 1'b0;
    chk("unhalt_pc4", id_pc, 32'h4);

    // Misaligned redirect -> sticky fault
    redirect = 1'b1; redirect_pc = 32'h6;
    cyc(1);
    redirect = 1'b0;
    chk("fault_set", {31'b0, fetch_fault}, 32'd1);
    chk("fault_valid", {31'b0, id_valid}, 32'd0);
    chk("fault_halted", {31'b0, halted}, 32'd0);
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0;
    cyc(1);
    redirect = 1'b0;
    cyc(2);
    chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    chk("fault_valid2", {31'b0, id_valid}, 32'd0);
    chk("fault_addr", {26'b0, imem_addr}, 32'd2);
    #2 nreset = 1'b0; id_ready = 1'b0;
    #1;
    chk("fault_rst", {31'b0, fetch_fault}, 32'd0);
    chk("fault_rst_addr", {26'b0, imem_addr}, 32'd0);
    cyc(1);
    nreset = 1'b1;
    cyc(1);
    chk("rst_run_pc", id_pc, 32'h0);
    chk("rst_run_valid", {31'b0, id_valid}, 32'd1);

    // Wrap/alias past word 63
    redirect = 1'b1; redirect_pc = 32'hF8;
    cyc(1);
    redirect = 1'b0; id_ready = 1'b1;
    push(32'hF8, 32'h03E0_0013);
    push(32'hFC, 32'h03F0_0013);
    cyc(1);
    chk("wrap_f8", id_pc, 32'hF8);
    cyc(1);
    chk("wrap_fc", id_pc, 32'hFC);
    chk("wrap_addr", {26'b0, imem_addr}, 32'd0);
    cyc(1);
    id_ready = 1'b0;
    chk("wrap_pc100", id_pc, 32'h100);
    chk("wrap_instr", id_instr, 32'h0010_0093);

    // Async reset mid-stall, no clock edge
    #3 nreset = 1'b0;
    #1;
    chk("async_valid", {31'b0, id_valid}, 32'd0);
    chk("async_instr", id_instr, 32'h0000_0013);
    chk("async_pc", id_pc, 32'd0);
    chk("async_addr", {26'b0, imem_addr}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
